// File: rtl/data_mem.sv
// CPU data-memory responder: 240-byte RAM plus GPIO, timer and write-counter registers.
// Optional timer is built only when DATA_MEM_TIMER_EN is defined.
module data_mem #(
  parameter int unsigned GPIO_SYNC_STAGES = 2
) (
  input  logic       _iClk,
  input  logic       _iReset,
  input  logic [7:0] _iDataMemAddr,
  input  logic [7:0] _iDataMemWData,
  input  logic       _iDataMemWrite,
  output logic [7:0] _oDataMemRData,
  input  logic [7:0] _iGpio,
  output logic [7:0] _oGpio,
  output logic       _oTimerOvf
);

  localparam logic [7:0] AddrGpioOut   = 8'hF0;
  localparam logic [7:0] AddrGpioIn    = 8'hF1;
  localparam logic [7:0] AddrTimerCnt  = 8'hF2;
  localparam logic [7:0] AddrTimerCtrl = 8'hF3;
  localparam logic [7:0] AddrTimerStat = 8'hF4;
  localparam logic [7:0] AddrWrCount   = 8'hF5;

  logic [7:0] ram [0:239];
  logic [7:0] gpioOut_q;
  logic [GPIO_SYNC_STAGES-1:0][7:0] gpioSync_q;
  logic [7:0] wrCount_q;
  logic       isRam;

  assign isRam = (_iDataMemAddr < 8'hF0);

  // RAM has no reset; reset still blocks a same-cycle write.
  always_ff @(posedge _iClk) begin
    if (_iDataMemWrite && !_iReset && isRam) begin
      ram[_iDataMemAddr] <= _iDataMemWData;
    end
  end

  always_ff @(posedge _iClk) begin
    if (_iReset) begin
      gpioOut_q  <= 8'h00;
      gpioSync_q <= '0;
      wrCount_q  <= 8'h00;
    end else begin
      gpioSync_q <= {gpioSync_q[GPIO_SYNC_STAGES-2:0], _iGpio};
      if (_iDataMemWrite && _iDataMemAddr == AddrGpioOut) begin
        gpioOut_q <= _iDataMemWData;
      end
      if (_iDataMemWrite) begin
        if (_iDataMemAddr == AddrWrCount) begin
          wrCount_q <= 8'h00;
        end else if (wrCount_q != 8'hFF) begin
          wrCount_q <= wrCount_q + 8'd1;
        end
      end
    end
  end

`ifdef DATA_MEM_TIMER_EN
  logic [7:0] timerCnt_q;
  logic       timerEn_q;
  logic [3:0] timerPresc_q;
  logic [3:0] prescCnt_q;
  logic       ovf_q;
  logic       tick;
  logic       cntWr;

  assign tick  = timerEn_q && (prescCnt_q == timerPresc_q);
  assign cntWr = _iDataMemWrite && (_iDataMemAddr == AddrTimerCnt);

  // Later assignments take priority: register writes override counting.
  always_ff @(posedge _iClk) begin
    if (_iReset) begin
      timerCnt_q   <= 8'h00;
      timerEn_q    <= 1'b0;
      timerPresc_q <= 4'h0;
      prescCnt_q   <= 4'h0;
      ovf_q        <= 1'b0;
    end else begin
      if (tick) begin
        prescCnt_q <= 4'h0;
        timerCnt_q <= timerCnt_q + 8'd1;
      end else if (timerEn_q) begin
        prescCnt_q <= prescCnt_q + 4'd1;
      end
      if (cntWr) begin
        timerCnt_q <= _iDataMemWData;
        prescCnt_q <= 4'h0;
      end
      if (_iDataMemWrite && _iDataMemAddr == AddrTimerCtrl) begin
        timerEn_q    <= _iDataMemWData[0];
        timerPresc_q <= _iDataMemWData[7:4];
        prescCnt_q   <= 4'h0;
      end
      // Overflow set beats a same-cycle write-1-to-clear.
      if (tick && !cntWr && timerCnt_q == 8'hFF) begin
        ovf_q <= 1'b1;
      end else if (_iDataMemWrite && _iDataMemAddr == AddrTimerStat && _iDataMemWData[0]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign _oTimerOvf = ovf_q;
`else
  assign _oTimerOvf = 1'b0;
`endif

  always_comb begin
    _oDataMemRData = 8'h00;
    if (isRam) begin
      _oDataMemRData = ram[_iDataMemAddr];
    end else begin
      unique case (_iDataMemAddr)
        AddrGpioOut:   _oDataMemRData = gpioOut_q;
        AddrGpioIn:    _oDataMemRData = gpioSync_q[GPIO_SYNC_STAGES-1];
`ifdef DATA_MEM_TIMER_EN
        AddrTimerCnt:  _oDataMemRData = timerCnt_q;
        AddrTimerCtrl: _oDataMemRData = {timerPresc_q, 3'b000, timerEn_q};
        AddrTimerStat: _oDataMemRData = {7'b0000000, ovf_q};
`endif
        AddrWrCount:   _oDataMemRData = wrCount_q;
        default:       _oDataMemRData = 8'h00;
      endcase
    end
  end

  assign _oGpio = gpioOut_q;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter GPIO_SYNC_STAGES, default 2, is the synchroniser depth on _iGpio; legal values are 2..4.
REQ-002 Port _iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port _iReset, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port _iDataMemAddr, input, 8 bits: byte address driven by the CPU.
REQ-005 Port _iDataMemWData, input, 8 bits: write data.
REQ-006 Port _iDataMemWrite, input, 1 bit: write strobe; one write per cycle in which it is high.
REQ-007 Port _oDataMemRData, output, 8 bits: read data for _iDataMemAddr.
REQ-008 Port _iGpio, input, 8 bits: asynchronous general-purpose inputs.
REQ-009 Port _oGpio, output, 8 bits: GPIO_OUT register contents.
REQ-010 Port _oTimerOvf, output, 1 bit: level copy of the TIMER_STAT.OVF flag.

Function
REQ-011 The block SHALL be the responder for the CPU data-memory bus; there SHALL be no handshake beyond the write strobe.
REQ-012 _oDataMemRData SHALL be combinational from _iDataMemAddr and stored state, valid in the same cycle as the address (zero-cycle read latency).
REQ-013 A write SHALL take effect at the rising edge where _iDataMemWrite=1; a read of the same address in the following cycle SHALL return the new value.
REQ-014 Address map SHALL be:
- 0x00-0xEF: RAM, 240 bytes
- 0xF0: GPIO_OUT (R/W)
- 0xF1: GPIO_IN (RO)
- 0xF2: TIMER_CNT (R/W)
- 0xF3: TIMER_CTRL (R/W; bit0 EN, bits7:4 PRESC, bits3:1 read 0)
- 0xF4: TIMER_STAT (bit0 OVF, write-1-to-clear)
- 0xF5: WR_COUNT (R; any write clears)
REQ-015 Addresses 0xF6-0xFF SHALL read 0x00; writes to them SHALL be ignored, except that they are counted per REQ-021.
REQ-016 GPIO_IN SHALL return _iGpio after GPIO_SYNC_STAGES flops; writes to GPIO_IN SHALL be ignored.
REQ-017 When EN=1, a prescale counter SHALL count 0..PRESC; TIMER_CNT SHALL increment by 1 (mod 256) on each cycle in which the prescale counter equals PRESC; the prescale counter then returns to 0.
REQ-018 When EN=0, both the prescale counter and TIMER_CNT SHALL hold.
REQ-019 A write to TIMER_CNT SHALL load the written value and zero the prescale counter; the write wins over a same-cycle increment. A write to TIMER_CTRL SHALL also zero the prescale counter.
REQ-020 OVF SHALL set on a TIMER_CNT increment from 0xFF to 0x00; a write to TIMER_STAT with bit0=1 SHALL clear OVF; if set and clear occur in the same cycle, set SHALL win.
REQ-021 WR_COUNT SHALL increment on every write to any address and saturate at 0xFF; a write to 0xF5 SHALL clear it to 0x00 and SHALL NOT itself be counted.

Reset
REQ-022 On reset: GPIO_OUT, TIMER_CNT, TIMER_CTRL, the prescale counter, OVF, WR_COUNT and the synchroniser flops SHALL be 0. Outputs therefore reset to _oGpio=0x00 and _oTimerOvf=0.
REQ-023 RAM contents SHALL NOT be affected by reset.
REQ-024 Reset SHALL dominate a same-cycle write.
REQ-025 Reset asserted mid-count SHALL stop the timer, since EN=0 after reset.

Configuration
REQ-026 With macro DATA_MEM_TIMER_EN defined, the timer SHALL be implemented per REQ-017 to REQ-020.
REQ-027 Without DATA_MEM_TIMER_EN:
- no timer logic SHALL be synthesised
- 0xF2-0xF4 SHALL read 0x00
- writes to 0xF2-0xF4 SHALL be ignored, except that they are counted in WR_COUNT
- _oTimerOvf SHALL be tied to 0

Verification
REQ-028 Write 0xA5 to 0x10, then read 0x10 the next cycle -> _oDataMemRData=0xA5; read 0xF8 -> 0x00.
REQ-029 Drive _iGpio=0x3C at cycle N -> GPIO_IN reads 0x3C from cycle N+GPIO_SYNC_STAGES; write 0x81 to 0xF0 -> _oGpio=0x81 the next cycle.
REQ-030 Write TIMER_CNT=0xFE, then TIMER_CTRL=0x21 (PRESC=2, EN=1) -> TIMER_CNT=0xFF after 3 cycles, then 0x00 after 3 more, with OVF=1 and _oTimerOvf=1.
REQ-031 With OVF=1, write 0x01 to 0xF4 in the same cycle as a 0xFF->0x00 wrap -> OVF stays 1; the next clear with no wrap -> OVF=0.
REQ-032 Perform 300 writes -> WR_COUNT=0xFF; write to 0xF5 -> WR_COUNT=0x00; assert reset after writing RAM 0x20=0x55 -> 0x20 still reads 0x55 and all registers read 0x00.
